// File: rtl/pw_bit_rx.sv
`timescale 1ns/1ps
// pw_bit_rx -- pulse-width bit receiver with AXI-Stream output.
//
// Decodes a pulse-width line into bits. A high pulse of at least `threshold`
// cycles is a 1, and a shorter pulse is a 0. Bits are packed MSB-first into
// output words. A frame ends when the line stays low, or stays high, for
// `timeout` cycles. The final partial word of a frame is left-justified and
// flagged with tuser.
//
// Ports
//   aclk, areset          clock; synchronous active-high reset
//   rxd                   asynchronous pulse-width input, idles low
//   data_m_axis_*         decoded words (tdata/tlast/tuser/tvalid/tready)
//   cfg_s_axis_*          config {period, t_one, t_zero}; ready only when idle
//   overrun               sticky: a completed word was dropped; cleared by cfg
module pw_bit_rx #(
  parameter int COUNTER_WIDTH        = 32,
  parameter int DATA_AXIS_DATA_WIDTH = 8,
  parameter int CFG_AXIS_DATA_WIDTH  = COUNTER_WIDTH * 3
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            rxd,
  output logic [DATA_AXIS_DATA_WIDTH-1:0] data_m_axis_tdata,
  output logic                            data_m_axis_tlast,
  output logic                            data_m_axis_tuser,
  output logic                            data_m_axis_tvalid,
  input  logic                            data_m_axis_tready,
  input  logic [CFG_AXIS_DATA_WIDTH-1:0]  cfg_s_axis_tdata,
  input  logic                            cfg_s_axis_tvalid,
  output logic                            cfg_s_axis_tready,
  output logic                            overrun
);
  localparam int CW  = COUNTER_WIDTH;
  localparam int DW  = DATA_AXIS_DATA_WIDTH;
  localparam int BCW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t          state, state_next;
  logic            rxd_meta, rxd_sync, rxd_prev, rise, fall;
  logic            cfg_loaded;
  logic [CW-1:0]   cfg_period, cfg_t_one, cfg_t_zero;
  logic [CW:0]     threshold, timeout;
  logic [CW-1:0]   hi_cnt, hi_next, lo_cnt, lo_next;
  logic            shift_en, shift_bit, frame_end, release_rise;
  logic [DW-1:0]   sr, sr_shifted, sr_after, partial;
  logic [BCW-1:0]  bit_cnt, bits_after;
  logic            word_done;
  // Pending holds one finished word. "armed" means a release was already
  // requested, so the word moves out as soon as the output register frees up.
  logic            pend_valid, pend_last, pend_user, pend_armed;
  logic [DW-1:0]   pend_data;
  // Tail parks a frame's partial word while pending is still occupied.
  logic            tail_valid;
  logic [DW-1:0]   tail_data;
  logic            p_valid, p_last, p_user, p_armed, t_valid;
  logic [DW-1:0]   p_data, t_data, out_d;
  logic            out_l, out_u, out_load, out_free, ovr_set, cfg_fire;

  assign cfg_s_axis_tready = (state == IDLE);
  assign cfg_fire          = cfg_s_axis_tvalid && cfg_s_axis_tready;
  assign threshold         = ({1'b0, cfg_t_one} + {1'b0, cfg_t_zero}) >> 1;
  assign timeout           = {cfg_period, 1'b0};
  assign out_free          = !data_m_axis_tvalid || data_m_axis_tready;

  // Two-flop synchronizer followed by registered edge pulses. Both edges see
  // the same delay, so the measured pulse widths are unchanged.
  // NOTE: sequential state uses non-blocking (<=) so that every flop samples
  // pre-edge values, whatever the order of the statements.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rxd_meta <= 1'b0;
      rxd_sync <= 1'b0;
      rxd_prev <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      rise     <= rxd_sync & ~rxd_prev;
      fall     <= ~rxd_sync & rxd_prev;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // a signal unassigned would infer a latch.
  always_comb begin
    state_next   = state;
    hi_next      = hi_cnt;
    lo_next      = lo_cnt;
    shift_en     = 1'b0;
    shift_bit    = 1'b0;
    frame_end    = 1'b0;
    release_rise = 1'b0;
    unique case (state)
      IDLE: if (rise && cfg_loaded) begin
        state_next = HIGH;
        hi_next    = CW'(1);
      end
      HIGH: if (fall) begin
        shift_en   = 1'b1;
        shift_bit  = ({1'b0, hi_cnt} >= threshold);
        state_next = LOW;
        lo_next    = CW'(1);
      end else if ({1'b0, hi_cnt} >= timeout) begin
        // A stuck-high line still counts as a 1, and it ends the frame.
        shift_en   = 1'b1;
        shift_bit  = 1'b1;
        frame_end  = 1'b1;
        state_next = IDLE;
      end else begin
        hi_next = (&hi_cnt) ? hi_cnt : hi_cnt + CW'(1);
      end
      LOW: if (rise) begin
        state_next   = HIGH;
        hi_next      = CW'(1);
        release_rise = 1'b1;
      end else if ({1'b0, lo_cnt} >= timeout) begin
        frame_end  = 1'b1;
        state_next = IDLE;
      end else begin
        lo_next = (&lo_cnt) ? lo_cnt : lo_cnt + CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift datapath. The partial word is justified by shifting out stale bits.
  always_comb begin
    sr_shifted = {sr[DW-2:0], shift_bit};
    word_done  = shift_en && (bit_cnt == BCW'(DW - 1));
    sr_after   = shift_en ? sr_shifted : sr;
    if (!shift_en)      bits_after = bit_cnt;
    else if (word_done) bits_after = '0;
    else                bits_after = bit_cnt + BCW'(1);
    partial    = sr_after << (BCW'(DW) - bits_after);
  end

  // Word routing, oldest first: pending -> output, then tail -> pending, then
  // a newly completed word, and finally a new partial tail.
  always_comb begin
    p_valid = pend_valid;
    p_data  = pend_data;
    p_last  = pend_last;
    p_user  = pend_user;
    p_armed = pend_armed;
    t_valid = tail_valid;
    t_data  = tail_data;
    ovr_set = 1'b0;
    if (p_valid && (release_rise || frame_end)) p_armed = 1'b1;
    if (p_valid && frame_end && bits_after == '0 && !word_done) p_last = 1'b1;
    out_load = p_valid && p_armed && out_free;
    out_d    = p_data;
    out_l    = p_last;
    out_u    = p_user;
    if (out_load) p_valid = 1'b0;
    if (t_valid && !p_valid) begin
      {p_valid, p_data, p_last, p_user, p_armed} = {1'b1, t_data, 3'b111};
      t_valid = 1'b0;
    end
    if (word_done) begin
      if (!p_valid) {p_valid, p_data, p_last, p_user, p_armed} =
                      {1'b1, sr_shifted, frame_end, 1'b0, frame_end};
      else          ovr_set = 1'b1;
    end
    if (frame_end && bits_after != '0) begin
      if (!p_valid)      {p_valid, p_data, p_last, p_user, p_armed} = {1'b1, partial, 3'b111};
      else if (!t_valid) {t_valid, t_data} = {1'b1, partial};
      else               ovr_set = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state              <= IDLE;
      hi_cnt             <= '0;
      lo_cnt             <= '0;
      sr                 <= '0;
      bit_cnt            <= '0;
      {pend_valid, pend_last, pend_user, pend_armed} <= '0;
      pend_data          <= '0;
      tail_valid         <= 1'b0;
      tail_data          <= '0;
      data_m_axis_tvalid <= 1'b0;
      data_m_axis_tdata  <= '0;
      data_m_axis_tlast  <= 1'b0;
      data_m_axis_tuser  <= 1'b0;
      cfg_loaded         <= 1'b0;
      cfg_period         <= '0;
      cfg_t_one          <= '0;
      cfg_t_zero         <= '0;
      overrun            <= 1'b0;
    end else begin
      state      <= state_next;
      hi_cnt     <= hi_next;
      lo_cnt     <= lo_next;
      if (shift_en) sr <= sr_shifted;
      bit_cnt    <= frame_end ? '0 : bits_after;
      {pend_valid, pend_last, pend_user, pend_armed} <= {p_valid, p_last, p_user, p_armed};
      pend_data  <= p_data;
      tail_valid <= t_valid;
      tail_data  <= t_data;
      if (out_load) begin
        data_m_axis_tvalid <= 1'b1;
        data_m_axis_tdata  <= out_d;
        data_m_axis_tlast  <= out_l;
        data_m_axis_tuser  <= out_u;
      end else if (data_m_axis_tvalid && data_m_axis_tready) begin
        data_m_axis_tvalid <= 1'b0;
        data_m_axis_tdata  <= '0;
        data_m_axis_tlast  <= 1'b0;
        data_m_axis_tuser  <= 1'b0;
      end
      if (cfg_fire) begin
        cfg_period <= cfg_s_axis_tdata[3*CW-1:2*CW];
        cfg_t_one  <= cfg_s_axis_tdata[2*CW-1:CW];
        cfg_t_zero <= cfg_s_axis_tdata[CW-1:0];
        cfg_loaded <= 1'b1;
        overrun    <= 1'b0;
      end else if (ovr_set) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
